// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-side
// valid/stall handshake and the execute-side redirect request.
interface fetch_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0] imem_addr;
  logic          imem_rd_en;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  // Fetch unit side
  modport master (
    output imem_addr, imem_rd_en, instr, instr_pc, instr_valid,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_addr, imem_rd_en, instr, instr_pc, instr_valid,
    output imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a one-cycle-latency
// instruction memory and hands instructions to decode in program order.
// A one-entry skid register absorbs the response already in flight when
// decode stalls, so full throughput is kept without losing data.
//
//   state | meaning
//   IDLE  | just out of reset, no reads issued
//   RUN   | fetching; reads issued while fewer than 2 slots are committed
module fetch_unit #(
  parameter int            AW       = 5,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] PC_START = AW'(12),
  parameter logic [AW-1:0] PC_LAST  = AW'(18)
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic          drop_q, drop_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          instr_valid_q, instr_valid_d;
  logic [DW-1:0] skid_instr_q, skid_instr_d;
  logic [AW-1:0] skid_pc_q, skid_pc_d;
  logic          skid_valid_q, skid_valid_d;

  logic          run;
  logic          consumed;
  logic          resp;
  logic          out_free;
  logic          rd_en;
  logic [1:0]    occ;

  // Next-state: read issue, response steering (output vs skid), redirect flush
  always_comb begin
    run      = (state_q == ST_RUN) && !rst;
    consumed = instr_valid_q && !bus.stall;
    resp     = inflight_q && !drop_q;
    // committed slots after this cycle's consume; never exceeds 2
    occ      = {1'b0, instr_valid_q} + {1'b0, skid_valid_q}
             + {1'b0, inflight_q} - {1'b0, consumed};
    rd_en    = run && !bus.redirect && (occ < 2'd2);
    out_free = !instr_valid_q || consumed;

    state_d       = ST_RUN;
    pc_d          = pc_q;
    inflight_d    = rd_en;
    inflight_pc_d = inflight_pc_q;
    drop_d        = 1'b0;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    skid_valid_d  = skid_valid_q;

    if (rd_en) begin
      inflight_pc_d = pc_q;
      pc_d          = (pc_q == PC_LAST) ? PC_START : pc_q + AW'(1);
    end

    if (run && bus.redirect) begin
      // any response arriving now belongs to the old path
      pc_d          = bus.redirect_pc;
      instr_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
      drop_d        = inflight_q;
    end else if (out_free) begin
      if (skid_valid_q) begin
        instr_d       = skid_instr_q;
        instr_pc_d    = skid_pc_q;
        instr_valid_d = 1'b1;
        skid_valid_d  = resp;
        if (resp) begin
          skid_instr_d = bus.imem_rdata;
          skid_pc_d    = inflight_pc_q;
        end
      end else if (resp) begin
        instr_d       = bus.imem_rdata;
        instr_pc_d    = inflight_pc_q;
        instr_valid_d = 1'b1;
      end else begin
        instr_valid_d = 1'b0;
      end
    end else if (resp) begin
      skid_instr_d = bus.imem_rdata;
      skid_pc_d    = inflight_pc_q;
      skid_valid_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= PC_START;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      skid_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.imem_rd_en  = rd_en;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of `instruction_decoder`/`alu`. It owns the program counter and drives read requests to the instruction memory, which has a fixed one-cycle read latency. It delivers instructions in program order to the decode stage over a valid/stall handshake and accepts PC redirects for `j`/`jal` from execute. A one-entry skid buffer lets it sustain one instruction per cycle without losing in-flight data when decode stalls.

## Interface
- `AW`, 5, PC/instruction-memory address width (word addresses).
- `DW`, 32, instruction width.
- `PC_START`, 12, PC loaded at reset and the wrap target.
- `PC_LAST`, 18, last PC of the program window; the increment from here goes to `PC_START`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  AW  read address; equals the internal PC register.
- `imem_rd_en`  out  1  read request this cycle.
- `imem_rdata`  in  DW  read data; valid in the cycle after `imem_rd_en`.
- `instr`  out  DW  instruction to decode.
- `instr_pc`  out  AW  address `instr` was fetched from.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid instruction.
- `stall`  in  1  decode cannot accept; consumed = `instr_valid && !stall`.
- `redirect`  in  1  single-cycle redirect request from execute.
- `redirect_pc`  in  AW  new fetch target when `redirect` is high.

## Operation
- State machine:
  - IDLE: entered on reset; no reads.
  - RUN: entered unconditionally one cycle after `rst` falls.
- Internal storage:
  - `pc`
  - `inflight` (1 bit) plus `inflight_pc`
  - `drop` (1 bit)
  - output register (`instr`, `instr_pc`, `instr_valid`)
  - skid register (`skid_instr`, `skid_pc`, `skid_valid`)
- Occupancy is `occ = instr_valid + skid_valid + inflight - consumed`.
  - `imem_rd_en = RUN && !redirect && occ < 2`.
- On a read:
  - set `inflight <= 1` and `inflight_pc <= pc`.
  - `pc <= (pc == PC_LAST) ? PC_START : pc + 1`. Outside the window, the increment is modulo 2^AW.
- On response (`inflight` set and `drop` clear), data goes to the output register if that register is empty or being consumed this cycle. Otherwise it goes to the skid register.
- On consume: the skid contents, if valid, move to the output register. The skid register then takes the response, if one arrives. Program order is always preserved.
- On `redirect` (RUN only):
  - `pc <= redirect_pc`
  - `instr_valid <= 0`, `skid_valid <= 0`
  - a response arriving next cycle for a read issued this cycle is impossible, because `rd_en` is forced low. Any read already in flight has `drop <= 1`, so its data is discarded.
  - The first read at `redirect_pc` is issued in the next cycle.
- Priority: `rst` > `redirect` > `stall`. `redirect` in IDLE is ignored.
- Reset values:
  - `pc = PC_START`, so `imem_addr = PC_START`
  - `imem_rd_en = 0`
  - `instr = 0`, `instr_pc = 0`, `instr_valid = 0`
  - skid, `inflight` and `drop` all cleared
- Reset mid-operation: all in-flight and buffered instructions are discarded, and the PC returns to `PC_START`.

## Timing
- Cycle 0 is the first cycle with `rst` low (IDLE).
- Cycle 1: `imem_rd_en = 1`, `imem_addr = PC_START`.
- Cycle 2: `imem_rdata` is valid; it is captured at the end of cycle 2.
- Cycle 3: `instr_valid = 1`.
- Steady-state latency is 2 cycles from `imem_rd_en` to `instr_valid`. Throughput is 1 instruction per cycle with no stall.
- Stall:
  - `instr`, `instr_pc` and `instr_valid` hold stable while `stall && instr_valid`.
  - At most one further response is absorbed by the skid register.
  - `imem_rd_en` drops within the same cycle that `occ` reaches 2.
- Redirect asserted in cycle t:
  - `instr_valid = 0` in cycle t+1.
  - read of `redirect_pc` in cycle t+1.
  - `instr_valid = 1` with that instruction in cycle t+3.
- Wrap: the read at `PC_LAST` is followed in the next issuing cycle by a read at `PC_START`.

## Test plan
- Reset release, memory preloaded `mem[12..18]` with distinct words, `stall=0`:
  - `imem_addr` sequence 12,13,…,18,12 on consecutive cycles from cycle 1.
  - `instr_valid` first high in cycle 3 with `instr=mem[12]`, `instr_pc=12`.
- Stall held 4 cycles starting when `instr_pc=13`:
  - output holds `mem[13]` for all 4 cycles.
  - `imem_rd_en` low after occupancy reaches 2.
  - on release, instructions 14,15,… emerge with no gap and no loss.
- `redirect=1`, `redirect_pc=15` while PC 13 is in flight and 12 is at the output:
  - next cycle `instr_valid=0`.
  - the response for 13 is discarded.
  - `instr_pc=15` appears 3 cycles after the redirect.
- `redirect` and `stall` in the same cycle with the skid register full:
  - both entries are flushed.
  - the fetch of `redirect_pc` proceeds.
- Reset asserted mid-stream with skid full and a read in flight:
  - next cycle all outputs are at reset values, `imem_addr=12`.
  - the sequence restarts per the reset-release scenario.
- `redirect_pc=30` (outside the window): fetch sequence 30,31,0,1,… (modulo 2^AW).
